// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and a per-entry busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto colliding reads.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [Depth];
  logic [DATA_W-1:0]        mem_d [Depth];
  logic [Depth-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [ADDR_W-1:0]        wa;
  logic [ADDR_W-1:0]        ra;

  // Ascending port order lets the highest-index writer overwrite lower ones.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    wa     = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wa = wr_addr[p*ADDR_W +: ADDR_W];
      if (wr_en[p] && (wa != '0)) begin
        mem_d[wa]  = wr_data[p*DATA_W +: DATA_W];
        busy_d[wa] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        ra = rd_addr[p*ADDR_W +: ADDR_W];
        rd_data_d[p*DATA_W +: DATA_W] = mem_q[ra];
        rd_busy_d[p]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned q = 0; q < NUM_WR; q++) begin
          if (wr_en[q] && (wr_addr[q*ADDR_W +: ADDR_W] == ra) && (ra != '0)) begin
            rd_data_d[p*DATA_W +: DATA_W] = wr_data[q*DATA_W +: DATA_W];
            // A same-cycle reservation keeps the pre-edge busy view.
            rd_busy_d[p] = (rsv_en && (rsv_addr == ra)) ? busy_q[ra] : 1'b0;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      mem_q     <= mem_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              flush;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DW-1:0]    m_mem [32];
  logic [31:0]      m_busy;
  logic [NR*DW-1:0] exp_data;
  logic [NR-1:0]    exp_busy;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0; exp_data = '0; exp_busy = '0;
  endtask

  // Advance the model by one clock edge from the current inputs, then step the DUT.
  task automatic cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] nd;
    logic          nb;
    logic [31:0]   written;
    for (int p = 0; p < NR; p++) begin
      if (rd_en[p]) begin
        a  = rd_addr[p*AW +: AW];
        nd = m_mem[a];
        nb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0) begin
          for (int q = 0; q < NW; q++) begin
            if (wr_en[q] && wr_addr[q*AW +: AW] == a) begin
              nd = wr_data[q*DW +: DW];
              nb = (rsv_en && rsv_addr == a) ? m_busy[a] : 1'b0;
            end
          end
        end
`endif
        exp_data[p*DW +: DW] = nd;
        exp_busy[p]          = nb;
      end
    end
    written = '0;
    for (int q = 0; q < NW; q++) begin
      a = wr_addr[q*AW +: AW];
      if (wr_en[q] && a != 0) begin
        m_mem[a]   = wr_data[q*DW +: DW];
        written[a] = 1'b1;
      end
    end
    for (int i = 1; i < 32; i++) begin
      if (flush) m_busy[i] = 1'b0;
      else if (rsv_en && rsv_addr == AW'(i)) m_busy[i] = 1'b1;
      else if (written[i]) m_busy[i] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0)
      $display("FAIL reset_outputs: data=%h busy=%b, expected 0/0", rd_data, rd_busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_en = 2'b11;
      rd_addr = {AW'(31 - a), AW'(a)};
      cycle();
      n_checks++;
      if (rd_data !== '0 || rd_busy !== '0)
        $display("FAIL reset_read_%0d: data=%h busy=%b, expected 0/0", a, rd_data, rd_busy);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_write_read();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'hDEADBEEF};
    cycle();
    idle();
    rd_en = 2'b01; rd_addr = {AW'(0), AW'(5)};
    cycle();
    idle();
    n_checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0)
      $display("FAIL write_read_x5: data=%h busy=%b, expected deadbeef/0",
               rd_data[DW-1:0], rd_busy[0]);
    else n_pass++;
  endtask

  task automatic test_write_priority();
    wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'h2222, 32'h1111};
    cycle();
    idle();
    rd_en = 2'b10; rd_addr = {AW'(7), AW'(0)};
    cycle();
    idle();
    n_checks++;
    if (rd_data[2*DW-1:DW] !== 32'h2222)
      $display("FAIL write_priority_x7: data=%h, expected 2222", rd_data[2*DW-1:DW]);
    else n_pass++;
    n_checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF)
      $display("FAIL read_hold_port0: data=%h, expected deadbeef", rd_data[DW-1:0]);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    wr_en = 2'b10; wr_addr = {AW'(0), AW'(0)}; wr_data = {32'hFFFF_FFFF, 32'h0};
    cycle();
    idle();
    rsv_en = 1'b1; rsv_addr = '0;
    cycle();
    idle();
    rd_en = 2'b11; rd_addr = '0;
    cycle();
    idle();
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0)
      $display("FAIL zero_reg: data=%h busy=%b, expected 0/00", rd_data, rd_busy);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    logic [3:0] got;
    got = '0;
    rsv_en = 1'b1; rsv_addr = AW'(3);
    cycle(); idle();
    rd_en = 2'b01; rd_addr = {AW'(0), AW'(3)};
    cycle(); idle();
    got[0] = rd_busy[0];
    rsv_en = 1'b1; rsv_addr = AW'(3);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(3)}; wr_data = {32'h0, 32'h42};
    cycle(); idle();
    rd_en = 2'b01; rd_addr = {AW'(0), AW'(3)};
    cycle(); idle();
    got[1] = rd_busy[0];
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h42)
      $display("FAIL rsv_write_data_x3: data=%h, expected 42", rd_data[DW-1:0]);
    else n_pass++;
    wr_en = 2'b10; wr_addr = {AW'(3), AW'(0)}; wr_data = {32'h43, 32'h0};
    cycle(); idle();
    rd_en = 2'b01; rd_addr = {AW'(0), AW'(3)};
    cycle(); idle();
    got[2] = rd_busy[0];
    rsv_en = 1'b1; rsv_addr = AW'(3); flush = 1'b1;
    cycle(); idle();
    rd_en = 2'b01; rd_addr = {AW'(0), AW'(3)};
    cycle(); idle();
    got[3] = rd_busy[0];
    n_checks++;
    if (got !== 4'b0011)
      $display("FAIL busy_sequence_x3: busy history=%b, expected 0011", got);
    else n_pass++;
    // Read racing a reservation sees the pre-edge busy; the next read sees it set.
    rsv_en = 1'b1; rsv_addr = AW'(4);
    rd_en = 2'b10; rd_addr = {AW'(4), AW'(0)};
    cycle(); idle();
    got[0] = rd_busy[1];
    rd_en = 2'b10; rd_addr = {AW'(4), AW'(0)};
    cycle(); idle();
    got[1] = rd_busy[1];
    n_checks++;
    if (got[1:0] !== 2'b10)
      $display("FAIL read_rsv_collision_x4: busy=%b, expected 10", got[1:0]);
    else n_pass++;
    flush = 1'b1;
    cycle(); idle();
  endtask

  task automatic test_collision_and_reset();
    logic [DW-1:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'hABCD;
`else
    want = 32'h0;
`endif
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'hABCD};
    rd_en = 2'b10; rd_addr = {AW'(9), AW'(0)};
    cycle(); idle();
    n_checks++;
    if (rd_data[2*DW-1:DW] !== want)
      $display("FAIL rw_collision_x9: data=%h, expected %h", rd_data[2*DW-1:DW], want);
    else n_pass++;
    // Reset lands between edges while a write to x9 is pending.
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h1234};
    rd_en = 2'b11; rd_addr = {AW'(9), AW'(9)};
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0)
      $display("FAIL async_reset: data=%h busy=%b, expected 0/00", rd_data, rd_busy);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle();
    model_reset();
    rd_en = 2'b01; rd_addr = {AW'(0), AW'(9)};
    cycle(); idle();
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h0)
      $display("FAIL reset_midwrite_x9: data=%h, expected 0", rd_data[DW-1:0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      rd_en = NR'($urandom);
      wr_en = NW'($urandom);
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int q = 0; q < NW; q++) begin
        wr_addr[q*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[q*DW +: DW] = $urandom;
      end
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      cycle();
      n_checks++;
      if (rd_data !== exp_data || rd_busy !== exp_busy)
        $display("FAIL random_%0d: data=%h busy=%b, expected data=%h busy=%b",
                 it, rd_data, rd_busy, exp_data, exp_busy);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_priority();
    test_zero_reg();
    test_scoreboard();
    test_collision_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
